// File: rtl/jbi_ssi_master.sv
`default_nettype none
// ============================================================================
//  Module      : jbi_ssi_master
//  Description : Serial master for the SSI boot/config interface. Serializes
//                one read/write request at a time onto mosi with a generated
//                sck, waits for the slave's start bit on miso, then collects
//                the ack and (for reads) the returned data.
//  Revision    : 1.0 - initial release
// ============================================================================
module jbi_ssi_master #(
    parameter int ADDR_W  = 28,
    parameter int DATA_W  = 32,
    parameter int DIV     = 4,
    parameter int TO_BITS = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_vld,
    output logic              req_rdy,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_vld,
    input  logic              rsp_rdy,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              jbi_io_ssi_mosi,
    output logic              jbi_io_ssi_sck,
    input  logic              io_jbi_ssi_miso
);

    // Frame bits after the start bit: rw, address, write data
    localparam int c_SH_W   = 1 + ADDR_W + DATA_W;
    localparam int c_WR_LEN = 2 + ADDR_W + DATA_W;
    localparam int c_RD_LEN = 2 + ADDR_W;
    localparam int c_PH_W   = $clog2(DIV);
    localparam int c_BC_W   = $clog2(c_WR_LEN + 1);
    localparam int c_TO_W   = $clog2(TO_BITS + 1);

    localparam logic [c_PH_W-1:0] c_PH_ONE    = c_PH_W'(1);
    localparam logic [c_PH_W-1:0] c_PH_LAST   = c_PH_W'(DIV - 1);
    localparam logic [c_PH_W-1:0] c_PH_SAMPLE = c_PH_W'(DIV / 2);
    localparam logic [c_BC_W-1:0] c_BC_ONE    = c_BC_W'(1);
    localparam logic [c_BC_W-1:0] c_WR_LAST   = c_BC_W'(c_WR_LEN - 1);
    localparam logic [c_BC_W-1:0] c_RD_LAST   = c_BC_W'(c_RD_LEN - 1);
    localparam logic [c_BC_W-1:0] c_DATA_CNT  = c_BC_W'(DATA_W);
    localparam logic [c_TO_W-1:0] c_TO_ONE    = c_TO_W'(1);
    localparam logic [c_TO_W-1:0] c_TO_LAST   = c_TO_W'(TO_BITS - 1);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_SEND = 3'd1;
    localparam logic [2:0] c_WAIT = 3'd2;
    localparam logic [2:0] c_RECV = 3'd3;
    localparam logic [2:0] c_DONE = 3'd4;

    logic [2:0]        r_state;
    logic [c_PH_W-1:0] r_phase;
    logic [c_BC_W-1:0] r_bit_cnt;
    logic [c_TO_W-1:0] r_to_cnt;
    logic [c_SH_W-1:0] r_shift;
    logic              r_rw;
    logic              r_mosi;
    logic              r_sck;
    logic              r_meta;
    logic              r_miso_s;
    logic              r_rsp_vld;
    logic              r_err;
    logic              r_timeout;
    logic [DATA_W-1:0] r_rdata;

    logic [c_PH_W-1:0] w_phase_nxt;
    logic              w_bit_end;
    logic              w_sample;
    logic              w_sck_nxt;
    logic              w_last_bit;

    assign w_bit_end   = (r_phase == c_PH_LAST);
    assign w_sample    = (r_phase == c_PH_SAMPLE);
    assign w_phase_nxt = w_bit_end ? '0 : r_phase + c_PH_ONE;
    assign w_sck_nxt   = (w_phase_nxt >= c_PH_SAMPLE);
    assign w_last_bit  = (r_bit_cnt == (r_rw ? c_RD_LAST : c_WR_LAST));

    // Ready is gated by reset so it is low in every reset cycle and high in
    // the first cycle after release, when the state is already IDLE.
    assign req_rdy         = (r_state == c_IDLE) && !reset;
    assign rsp_vld         = r_rsp_vld;
    assign rsp_err         = r_err;
    assign rsp_timeout     = r_timeout;
    assign rsp_rdata       = r_rdata;
    assign jbi_io_ssi_mosi = r_mosi;
    assign jbi_io_ssi_sck  = r_sck;

    // Two-flop synchronizer for the asynchronous miso pad input
    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta   <= 1'b0;
            r_miso_s <= 1'b0;
        end else begin
            r_meta   <= io_jbi_ssi_miso;
            r_miso_s <= r_meta;
        end
    end

    // Transaction state machine with registered serial and response outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_phase   <= '0;
            r_bit_cnt <= '0;
            r_to_cnt  <= '0;
            r_shift   <= '0;
            r_rw      <= 1'b0;
            r_mosi    <= 1'b0;
            r_sck     <= 1'b0;
            r_rsp_vld <= 1'b0;
            r_err     <= 1'b0;
            r_timeout <= 1'b0;
            r_rdata   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_sck <= 1'b0;
                    if (req_vld) begin
                        // Start bit goes out immediately so it is on the
                        // wire in phase 0 of the first bit period.
                        r_state   <= c_SEND;
                        r_rw      <= req_rw;
                        r_shift   <= {req_rw, req_addr, req_wdata};
                        r_mosi    <= 1'b1;
                        r_phase   <= '0;
                        r_bit_cnt <= '0;
                        r_to_cnt  <= '0;
                        r_err     <= 1'b0;
                        r_timeout <= 1'b0;
                        r_rdata   <= '0;
                    end
                end

                c_SEND: begin
                    r_phase <= w_phase_nxt;
                    r_sck   <= w_sck_nxt;
                    if (w_bit_end) begin
                        if (w_last_bit) begin
                            r_state   <= c_WAIT;
                            r_mosi    <= 1'b0;
                            r_bit_cnt <= '0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + c_BC_ONE;
                            r_mosi    <= r_shift[c_SH_W-1];
                            r_shift   <= {r_shift[c_SH_W-2:0], 1'b0};
                        end
                    end
                end

                c_WAIT: begin
                    r_phase <= w_phase_nxt;
                    r_sck   <= w_sck_nxt;
                    if (w_sample) begin
                        if (r_miso_s) begin
                            r_state <= c_RECV;
                        end else if (r_to_cnt == c_TO_LAST) begin
                            r_state   <= c_DONE;
                            r_timeout <= 1'b1;
                            r_rsp_vld <= 1'b1;
                            r_sck     <= 1'b0;
                        end else begin
                            r_to_cnt <= r_to_cnt + c_TO_ONE;
                        end
                    end
                end

                c_RECV: begin
                    r_phase <= w_phase_nxt;
                    r_sck   <= w_sck_nxt;
                    if (w_sample) begin
                        if (r_bit_cnt == '0) begin
                            // Ack bit; only a successful read carries data
                            r_err <= r_miso_s;
                            if (!r_rw || r_miso_s) begin
                                r_state   <= c_DONE;
                                r_rsp_vld <= 1'b1;
                                r_sck     <= 1'b0;
                            end else begin
                                r_bit_cnt <= c_BC_ONE;
                            end
                        end else begin
                            r_rdata <= {r_rdata[DATA_W-2:0], r_miso_s};
                            if (r_bit_cnt == c_DATA_CNT) begin
                                r_state   <= c_DONE;
                                r_rsp_vld <= 1'b1;
                                r_sck     <= 1'b0;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + c_BC_ONE;
                            end
                        end
                    end
                end

                c_DONE: begin
                    r_sck <= 1'b0;
                    if (rsp_rdy) begin
                        r_state   <= c_IDLE;
                        r_rsp_vld <= 1'b0;
                    end
                end

                default: begin
                    r_state <= c_IDLE;
                    r_sck   <= 1'b0;
                    r_mosi  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jbi_ssi_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jbi_ssi_master
//  Description : Self-checking bench for jbi_ssi_master. Directed requests
//                with hand-computed frames and responses; expected responses
//                are queued at issue time and compared by a monitor on each
//                response handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jbi_ssi_master;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;
    localparam int DIV     = 4;
    localparam int TO_BITS = 16;
    localparam int c_CLK_P = 10;

    typedef struct packed {
        logic       err;
        logic       timeout;
        logic [7:0] rdata;
    } rsp_t;

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic       req_vld   = 1'b0;
    logic       req_rw    = 1'b0;
    logic [7:0] req_addr  = 8'h00;
    logic [7:0] req_wdata = 8'h00;
    logic       rsp_rdy   = 1'b0;
    logic       miso      = 1'b0;
    logic       req_rdy;
    logic       rsp_vld;
    logic       rsp_err;
    logic       rsp_timeout;
    logic [7:0] rsp_rdata;
    logic       mosi;
    logic       sck;

    rsp_t exp_q[$];
    rsp_t mon_e;
    int   vectors     = 0;
    int   miscompares = 0;
    int   lat;
    int   waits;
    int   n;
    time  t_rsp_hs    = 0;
    time  t_req_hs    = 0;

    jbi_ssi_master #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .DIV     (DIV),
        .TO_BITS (TO_BITS)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req_vld         (req_vld),
        .req_rdy         (req_rdy),
        .req_rw          (req_rw),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .rsp_vld         (rsp_vld),
        .rsp_rdy         (rsp_rdy),
        .rsp_err         (rsp_err),
        .rsp_timeout     (rsp_timeout),
        .rsp_rdata       (rsp_rdata),
        .jbi_io_ssi_mosi (mosi),
        .jbi_io_ssi_sck  (sck),
        .io_jbi_ssi_miso (miso)
    );

    always #(c_CLK_P / 2) clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Issue a request, then check every clk cycle of the outgoing frame.
    // Returns at phase 0 of the first WAIT bit period (or of bit abort_bits).
    task automatic send_req(input logic rw, input logic [7:0] addr,
                            input logic [7:0] wdata, input int abort_bits);
        logic [17:0] fr;
        int          len;
        int          w;
        fr        = {1'b1, rw, addr, wdata};
        len       = rw ? 10 : 18;
        req_vld   = 1'b1;
        req_rw    = rw;
        req_addr  = addr;
        req_wdata = wdata;
        w = 0;
        while (!req_rdy && w < 200) begin
            @(negedge clk);
            w++;
        end
        waits = w;
        if (!req_rdy) begin
            vectors++;
            miscompares++;
            $display("FAIL req_handshake: req_rdy stayed 0, expected 1 within 200 cycles");
            req_vld = 1'b0;
            return;
        end
        t_req_hs = $time;
        @(negedge clk);
        req_vld = 1'b0;
        for (int b = 0; b < len; b++) begin
            if (abort_bits >= 0 && b == abort_bits) return;
            for (int p = 0; p < DIV; p++) begin
                check($sformatf("mosi_bit%0d_ph%0d", b, p), mosi, fr[17-b]);
                check($sformatf("sck_bit%0d_ph%0d", b, p), sck, (p >= DIV / 2));
                if (p == 0) check("req_rdy_busy", req_rdy, 0);
                @(negedge clk);
            end
        end
        check("mosi_after_frame", mosi, 0);
    endtask

    // Slave response: zero_periods idle bit periods (optional 1-cycle glitch
    // away from the sampling phase), then nbits of bits, MSB first, each
    // changed at phase 0. lat = negedges from start-bit drive to rsp_vld.
    task automatic drive_resp(input int zero_periods, input logic glitch,
                              input logic [9:0] bits, input int nbits);
        int k;
        lat = -1;
        for (int z = 0; z < zero_periods; z++) begin
            for (int p = 0; p < DIV; p++) begin
                miso = glitch && (z == 0) && (p == DIV / 2);
                @(negedge clk);
            end
        end
        k = 0;
        for (int i = nbits - 1; i >= 0; i--) begin
            miso = bits[i];
            for (int p = 0; p < DIV; p++) begin
                @(negedge clk);
                k++;
                if (rsp_vld && lat < 0) lat = k;
            end
        end
        miso = 1'b0;
    endtask

    // Response monitor: compares each response handshake against the queue
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!reset && rsp_vld && rsp_rdy) begin
                t_rsp_hs = $time - 1;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_rsp: response seen (err=%0b to=%0b rdata=0x%0h), none expected",
                             rsp_err, rsp_timeout, rsp_rdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rsp_err", rsp_err, mon_e.err);
                    check("rsp_timeout", rsp_timeout, mon_e.timeout);
                    check("rsp_rdata", rsp_rdata, mon_e.rdata);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Directed stimulus
    initial begin
        // Power-on reset
        repeat (3) begin
            @(negedge clk);
            check("por_mosi", mosi, 0);
            check("por_sck", sck, 0);
            check("por_rsp_vld", rsp_vld, 0);
            check("por_req_rdy", req_rdy, 0);
            check("por_rsp_flags", {rsp_err, rsp_timeout, rsp_rdata}, 0);
        end
        reset = 1'b0;
        #1;
        check("req_rdy_after_por", req_rdy, 1);

        // Reset in the middle of a write frame aborts with no response
        rsp_rdy = 1'b1;
        @(negedge clk);
        send_req(1'b0, 8'h11, 8'h77, 5);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_mosi", mosi, 0);
            check("rst_sck", sck, 0);
            check("rst_rsp_vld", rsp_vld, 0);
            check("rst_req_rdy", req_rdy, 0);
        end
        reset = 1'b0;
        #1;
        check("req_rdy_after_rst", req_rdy, 1);
        repeat (8) begin
            @(negedge clk);
            check("idle_sck", sck, 0);
            check("idle_rsp_vld", rsp_vld, 0);
        end

        // Write 0xA5 to 0x3C, ack 0
        exp_q.push_back({1'b0, 1'b0, 8'h00});
        send_req(1'b0, 8'h3C, 8'hA5, -1);
        drive_resp(2, 1'b0, 10'b10, 2);
        check("write_rsp_latency", lat, DIV + 3);

        // Read 0x81, data 0x5A
        exp_q.push_back({1'b0, 1'b0, 8'h5A});
        send_req(1'b1, 8'h81, 8'h00, -1);
        drive_resp(0, 1'b0, {2'b10, 8'h5A}, 10);
        check("read_rsp_latency", lat, 9 * DIV + 3);

        // Read with error ack: no data bits, rdata cleared
        exp_q.push_back({1'b1, 1'b0, 8'h00});
        send_req(1'b1, 8'h42, 8'hFF, -1);
        drive_resp(1, 1'b0, 10'b11, 2);
        check("err_rsp_latency", lat, DIV + 3);

        // Read with miso held low: timeout, response held while rsp_rdy=0
        rsp_rdy = 1'b0;
        exp_q.push_back({1'b0, 1'b1, 8'h00});
        send_req(1'b1, 8'h7E, 8'h00, -1);
        n = 0;
        while (!rsp_vld && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("timeout_latency", n, TO_BITS * DIV - 1);
        req_vld  = 1'b1;
        req_rw   = 1'b0;
        req_addr = 8'h12;
        repeat (5) begin
            @(negedge clk);
            check("hold_rsp_vld", rsp_vld, 1);
            check("hold_rsp_timeout", rsp_timeout, 1);
            check("hold_rsp_err", rsp_err, 0);
            check("hold_rsp_rdata", rsp_rdata, 0);
            check("hold_req_rdy", req_rdy, 0);
            check("hold_sck", sck, 0);
        end
        req_vld = 1'b0;
        rsp_rdy = 1'b1;
        @(negedge clk);
        check("post_rsp_vld", rsp_vld, 0);
        check("post_req_rdy", req_rdy, 1);
        @(negedge clk);
        check("no_accept_req_rdy", req_rdy, 1);

        // Back-to-back: next request waits with req_vld high through the response
        exp_q.push_back({1'b0, 1'b0, 8'h3C});
        send_req(1'b1, 8'h55, 8'h00, -1);
        req_vld  = 1'b1;
        req_rw   = 1'b1;
        req_addr = 8'hF0;
        exp_q.push_back({1'b0, 1'b0, 8'hC3});
        drive_resp(1, 1'b0, {2'b10, 8'h3C}, 10);
        check("b2b_first_latency", lat, 9 * DIV + 3);
        send_req(1'b1, 8'hF0, 8'h00, -1);
        check("b2b_wait_cycles", waits, 0);
        check("b2b_handshake_gap", 32'(t_req_hs - t_rsp_hs), c_CLK_P);
        drive_resp(2, 1'b1, {2'b10, 8'hC3}, 10);
        check("glitch_rsp_latency", lat, 9 * DIV + 3);

        repeat (5) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
